// File: rtl/program_loader_pw.sv
// ---------------------------------------------------------------------------
// program_loader_pw
//
// Assembles bytes from the UART receiver into WORD_BYTES-wide words and
// writes them sequentially into instruction memory. Loading ends on an
// all-ones sentinel word. Writes beyond the memory depth are refused, and a
// partial word left idle for too long is discarded.
//
// Parameters:
//   WORD_BYTES     bytes per memory word (1..8), DATA_WIDTH = 8*WORD_BYTES
//   ADDR_WIDTH     width of write_addr / pc_init / word_count
//   MAX_WORDS      memory depth in words
//   BIG_ENDIAN     1: first byte -> MS byte, 0: first byte -> LS byte
//   TIMEOUT_CYCLES idle cycles allowed inside a word (>= 1)
//
// Ports:
//   CLK           clock
//   INITIALIZE    asynchronous active-high reset
//   needed        load enable; bytes accepted only while high
//   rx_data       received byte
//   rx_valid      one-cycle strobe qualifying rx_data
//   write_addr    memory write address (holds between writes)
//   write_data    memory write data (holds between writes)
//   write_enable  one-cycle write strobe
//   pc_init       address following the most recent marker word
//   word_count    words written so far (saturates at MAX_WORDS)
//   done          sentinel received (sticky)
//   overflow      word arrived with memory full (sticky)
//   timeout_err   partial word discarded by timeout (sticky)
//   fsm_state     current FSM state (0 LOAD, 1 DONE, 2 FULL) for observation
//
// Receive handshake: there is no back-pressure. rx_valid is a single-cycle
// strobe; a byte is taken on the CLK edge where needed && rx_valid is high
// and the loader is not in DONE. Bytes presented at any other edge are lost.
// ---------------------------------------------------------------------------
module program_loader_pw #(
    parameter int WORD_BYTES     = 4,
    parameter int ADDR_WIDTH     = 16,
    parameter int MAX_WORDS      = 1 << 14,
    parameter int BIG_ENDIAN     = 1,
    parameter int TIMEOUT_CYCLES = 1000000,
    localparam int DATA_WIDTH    = 8 * WORD_BYTES
) (
    input  logic                  CLK,
    input  logic                  INITIALIZE,
    input  logic                  needed,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  write_enable,
    output logic [ADDR_WIDTH-1:0] pc_init,
    output logic [ADDR_WIDTH-1:0] word_count,
    output logic                  done,
    output logic                  overflow,
    output logic                  timeout_err,
    output logic [1:0]            fsm_state
);

    localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    // One extra bit so the count can represent MAX_WORDS even when
    // MAX_WORDS == 2**ADDR_WIDTH.
    localparam int CNT_W = ADDR_WIDTH + 1;

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_DONE = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t                state_q;
    logic [IDX_W-1:0]      idx_q;
    logic [DATA_WIDTH-1:0] asm_q;
    logic                  first_ff_q;
    logic [TMO_W-1:0]      tmo_q;
    logic [CNT_W-1:0]      cnt_q;

    logic                  accept;
    logic                  last_byte;
    logic                  marker;
    logic                  sentinel;
    logic [DATA_WIDTH-1:0] word_next;
    logic [CNT_W-1:0]      cnt_inc;

    assign accept    = needed && rx_valid && (state_q != S_DONE);
    assign last_byte = (idx_q == LAST_IDX);
    // The marker test looks at the first byte of the word, which is the
    // incoming byte itself when the word has only one byte so far.
    assign marker    = (idx_q == '0) ? (rx_data == 8'hFF) : first_ff_q;
    assign sentinel  = &word_next;
    assign cnt_inc   = cnt_q + CNT_W'(1);

    assign word_count = cnt_q[ADDR_WIDTH-1:0];
    assign fsm_state  = state_q;

    // Word as it would look with the incoming byte placed in its lane.
    always_comb begin
        word_next = asm_q;
        if (BIG_ENDIAN != 0) begin
            word_next[(WORD_BYTES - 1 - int'(idx_q)) * 8 +: 8] = rx_data;
        end else begin
            word_next[int'(idx_q) * 8 +: 8] = rx_data;
        end
    end

    always_ff @(posedge CLK or posedge INITIALIZE) begin
        if (INITIALIZE) begin
            state_q      <= S_LOAD;
            idx_q        <= '0;
            asm_q        <= '0;
            first_ff_q   <= 1'b0;
            tmo_q        <= '0;
            cnt_q        <= '0;
            write_addr   <= '0;
            write_data   <= '0;
            write_enable <= 1'b0;
            pc_init      <= '0;
            done         <= 1'b0;
            overflow     <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            write_enable <= 1'b0;

            if (accept) begin
                tmo_q <= '0;
                if (last_byte) begin
                    idx_q      <= '0;
                    asm_q      <= '0;
                    first_ff_q <= 1'b0;
                    if (sentinel) begin
                        done    <= 1'b1;
                        state_q <= S_DONE;
                    end else if (cnt_q == MAX_CNT) begin
                        // Memory full: keep assembling so a sentinel can
                        // still finish the load, but never write.
                        overflow <= 1'b1;
                        state_q  <= S_FULL;
                    end else begin
                        write_addr   <= cnt_q[ADDR_WIDTH-1:0];
                        write_data   <= word_next;
                        write_enable <= 1'b1;
                        cnt_q        <= cnt_inc;
                        if (marker) begin
                            pc_init <= cnt_inc[ADDR_WIDTH-1:0];
                        end
                    end
                end else begin
                    idx_q <= idx_q + IDX_W'(1);
                    asm_q <= word_next;
                    if (idx_q == '0) begin
                        first_ff_q <= (rx_data == 8'hFF);
                    end
                end
            end else if (needed && (idx_q != '0)) begin
                // Idle inside a word. An accepted byte takes priority above,
                // so a byte on the expiry edge keeps the word alive.
                if (tmo_q == TMO_LAST) begin
                    idx_q       <= '0;
                    asm_q       <= '0;
                    first_ff_q  <= 1'b0;
                    tmo_q       <= '0;
                    timeout_err <= 1'b1;
                end else begin
                    tmo_q <= tmo_q + TMO_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_program_loader_pw.sv
module tb_program_loader_pw;

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_DONE = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic INITIALIZE = 1'b1;
    always #5 CLK = ~CLK;

    logic       needed = 1'b0;
    logic       needed_le = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;

    logic [15:0] write_addr, pc_init, word_count;
    logic [31:0] write_data;
    logic        write_enable, done, overflow, timeout_err;
    logic [1:0]  fsm_state;

    logic [15:0] write_addr_le, pc_init_le, word_count_le;
    logic [31:0] write_data_le;
    logic        write_enable_le, done_le, overflow_le, timeout_err_le;
    logic [1:0]  fsm_state_le;

    program_loader_pw #(
        .WORD_BYTES(4), .ADDR_WIDTH(16), .MAX_WORDS(4),
        .BIG_ENDIAN(1), .TIMEOUT_CYCLES(100)
    ) dut (
        .CLK(CLK), .INITIALIZE(INITIALIZE), .needed(needed),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .write_addr(write_addr), .write_data(write_data),
        .write_enable(write_enable), .pc_init(pc_init),
        .word_count(word_count), .done(done), .overflow(overflow),
        .timeout_err(timeout_err), .fsm_state(fsm_state)
    );

    program_loader_pw #(
        .WORD_BYTES(4), .ADDR_WIDTH(16), .MAX_WORDS(4),
        .BIG_ENDIAN(0), .TIMEOUT_CYCLES(100)
    ) dut_le (
        .CLK(CLK), .INITIALIZE(INITIALIZE), .needed(needed_le),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .write_addr(write_addr_le), .write_data(write_data_le),
        .write_enable(write_enable_le), .pc_init(pc_init_le),
        .word_count(word_count_le), .done(done_le), .overflow(overflow_le),
        .timeout_err(timeout_err_le), .fsm_state(fsm_state_le)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [47:0] exp_q[$];     // {addr, data} for the big-endian instance
    logic [47:0] exp_le_q[$];  // {addr, data} for the little-endian instance
    logic [15:0] exp_cnt = 16'd0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge CLK) begin
        logic [47:0] e;
        if (write_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {63'd0, write_enable}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("write", {16'd0, write_addr, write_data}, {16'd0, e});
            end
        end
        if (write_enable_le === 1'b1) begin
            if (exp_le_q.size() == 0) begin
                check("unexpected_write_le", {63'd0, write_enable_le}, 64'd0);
            end else begin
                e = exp_le_q.pop_front();
                check("write_le", {16'd0, write_addr_le, write_data_le}, {16'd0, e});
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All drivers are called at a negedge and return at a negedge.
    task automatic drive_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge CLK);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_word(input logic [31:0] w, input bit expect_write);
        if (expect_write) begin
            exp_q.push_back({exp_cnt, w});
            exp_cnt = exp_cnt + 16'd1;
        end
        for (int i = 3; i >= 0; i--) drive_byte(w[i*8 +: 8]);
    endtask

    task automatic do_reset();
        check("pending_writes", 64'(exp_q.size()), 64'd0);
        INITIALIZE = 1'b1;
        idle(2);
        INITIALIZE = 1'b0;
        exp_cnt = 16'd0;
        idle(1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"}, 64'(write_addr), 64'd0);
        check({tag, "_data"}, 64'(write_data), 64'd0);
        check({tag, "_we"}, 64'(write_enable), 64'd0);
        check({tag, "_pc"}, 64'(pc_init), 64'd0);
        check({tag, "_cnt"}, 64'(word_count), 64'd0);
        check({tag, "_flags"}, {61'd0, done, overflow, timeout_err}, 64'd0);
        check({tag, "_state"}, 64'(fsm_state), 64'(ST_LOAD));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        idle(2);
        check_all_zero("reset");
        INITIALIZE = 1'b0;
        idle(1);

        // 1: one big-endian word, back-to-back bytes
        needed = 1'b1;
        send_word(32'h12345678, 1'b1);
        idle(2);
        check("t1_count", 64'(word_count), 64'd1);
        check("t1_pc", 64'(pc_init), 64'd0);

        // 2: little-endian lane order on the second instance
        do_reset();
        needed = 1'b0;
        needed_le = 1'b1;
        exp_le_q.push_back({16'd0, 32'h78563412});
        send_word(32'h12345678, 1'b0);
        idle(2);
        needed_le = 1'b0;
        check("t2_le_count", 64'(word_count_le), 64'd1);
        check("t2_be_idle", 64'(word_count), 64'd0);

        // 3: marker word and sentinel
        do_reset();
        needed = 1'b1;
        send_word(32'h00000001, 1'b1);
        send_word(32'hFF000000, 1'b1);
        idle(1);
        check("t3_pc_after_marker", 64'(pc_init), 64'd2);
        send_word(32'h00000002, 1'b1);
        send_word(32'hFFFFFFFF, 1'b0);
        idle(1);
        check("t3_done", 64'(done), 64'd1);
        check("t3_count", 64'(word_count), 64'd3);
        check("t3_pc", 64'(pc_init), 64'd2);
        check("t3_state", 64'(fsm_state), 64'(ST_DONE));
        send_word(32'h11223344, 1'b0);
        idle(2);
        check("t3_count_after", 64'(word_count), 64'd3);

        // 4: overflow guard, then sentinel from FULL
        do_reset();
        needed = 1'b1;
        for (int k = 0; k < 4; k++) send_word(32'hA0000000 | 32'(k), 1'b1);
        idle(1);
        check("t4_no_overflow_yet", 64'(overflow), 64'd0);
        send_word(32'hA0000004, 1'b0);
        idle(1);
        check("t4_overflow", 64'(overflow), 64'd1);
        check("t4_count", 64'(word_count), 64'd4);
        check("t4_state_full", 64'(fsm_state), 64'(ST_FULL));
        check("t4_not_done", 64'(done), 64'd0);
        send_word(32'hFFFFFFFF, 1'b0);
        idle(1);
        check("t4_done", 64'(done), 64'd1);
        check("t4_state_done", 64'(fsm_state), 64'(ST_DONE));

        // 5a: timeout fires on the 100th idle edge
        do_reset();
        needed = 1'b1;
        drive_byte(8'hAA);
        drive_byte(8'hBB);
        idle(99);
        check("t5_tmo_early", 64'(timeout_err), 64'd0);
        idle(1);
        check("t5_tmo_fired", 64'(timeout_err), 64'd1);
        send_word(32'h01020304, 1'b1);
        idle(1);
        check("t5_count", 64'(word_count), 64'd1);

        // 5b: byte arriving on the expiry edge keeps the word
        do_reset();
        needed = 1'b1;
        exp_q.push_back({16'd0, 32'hAABB0304});
        exp_cnt = 16'd1;
        drive_byte(8'hAA);
        drive_byte(8'hBB);
        idle(99);
        drive_byte(8'h03);
        drive_byte(8'h04);
        idle(1);
        check("t5b_no_tmo", 64'(timeout_err), 64'd0);
        check("t5b_count", 64'(word_count), 64'd1);

        // 5c: needed low freezes the partial word and the timeout counter
        needed = 1'b1;
        drive_byte(8'hC1);
        needed = 1'b0;
        idle(150);
        needed = 1'b1;
        exp_q.push_back({exp_cnt, 32'hC1C2C3C4});
        exp_cnt = exp_cnt + 16'd1;
        drive_byte(8'hC2);
        drive_byte(8'hC3);
        drive_byte(8'hC4);
        idle(1);
        check("t5c_no_tmo", 64'(timeout_err), 64'd0);
        check("t5c_count", 64'(word_count), 64'd2);

        // 6: asynchronous reset in the middle of a word
        drive_byte(8'h55);
        drive_byte(8'h66);
        #1 INITIALIZE = 1'b1;
        #1 check_all_zero("async_reset");
        #1 INITIALIZE = 1'b0;
        exp_cnt = 16'd0;
        @(negedge CLK);
        send_word(32'h0A0B0C0D, 1'b1);
        idle(2);
        check("t6_count", 64'(word_count), 64'd1);
        check("t6_addr", 64'(write_addr), 64'd0);

        // final drain
        idle(2);
        check("final_pending", 64'(exp_q.size()), 64'd0);
        check("final_pending_le", 64'(exp_le_q.size()), 64'd0);
        check("final_le_flags", {60'd0, done_le, overflow_le, timeout_err_le, 1'b0}, 64'd0);
        check("final_le_state", {46'd0, fsm_state_le, pc_init_le}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
